usrt_link_ctrl: RTL and testbench
=================================

# usrt_link_ctrl

APB-slave controller that sequences the USRT serializer/deserializer pair. Holds software-visible control, status, baud and data registers; buffers outgoing bytes in a small FIFO, frames them and issues load strobes to the serializer; captures and checks frames delivered by the deserializer. Sits between the AMBA APB port and the serializer/deserializer datapath, replacing ad-hoc enable decoding with one clocked controller.

## Interface
- TX_DEPTH, 4, TX FIFO depth in bytes (power of two, ≥2)
- BAUD_DIV, 16, reset value of the BAUD register (pClk cycles per bit)
- pClk  in  1  sole clock, all logic rising-edge
- pReset  in  1  asynchronous, active-high reset
- pSelect, pEnable, pWrite  in  1 each  APB control
- pAddress  in  33  APB address; only bits [3:2] decoded, rest ignored
- pWData  in  8  APB write data
- pRData  out  8  APB read data; 0 whenever pReady is low
- pReady  out  1  APB completion
- txFrame  out  11  frame to serializer: [0] start=0, [8:1] data LSB-first, [9] even parity over data, [10] stop=1
- txLoad  out  1  one-cycle strobe, txFrame valid
- txBusy  in  1  serializer shifting
- rxFrame  in  11  frame from deserializer, same layout
- rxValid  in  1  one-cycle strobe, rxFrame valid
- baudTick  out  1  one-cycle bit-rate pulse to serializer/deserializer
- irq  out  1  level interrupt

## Operation
- Registers (pAddress[3:2]): 0 DATA (W: push TX FIFO; R: return RX byte, clear rxFull); 1 STATUS (RO): [0] txFull [1] txEmpty [2] rxFull [3] rxOverrun [4] parityErr [5] frameErr [6] txActive [7] txOverflow; 2 CTRL: [0] enable [1] txIrqEn [2] rxIrqEn [3] clrErr (write-1 pulse, reads 0); 3 BAUD: 8-bit divisor.
- Reset: all registers 0 except BAUD=BAUD_DIV; FIFO empty; FSM IDLE; pRData, pReady, txLoad, baudTick, irq = 0; txFrame = 11'h7FF.
- TX FSM: IDLE → (enable & FIFO non-empty) → LOAD: pop FIFO, register txFrame, txLoad=1 for one cycle → WAIT_BUSY: until txBusy=1 → WAIT_DONE: until txBusy=0 → IDLE. txActive = state≠IDLE.
- Push to full FIFO: byte dropped, txOverflow set. Push and pop in same cycle on full FIFO: both succeed, count unchanged.
- Clearing enable while txActive: current frame completes; FSM returns IDLE and stays; FIFO contents retained.
- RX on rxValid: frameErr set if [0]≠0 or [10]≠1; parityErr set on parity mismatch; byte [8:1] stored regardless of errors. If rxFull already set: rxOverrun set, new byte discarded, old byte kept. rxValid in same cycle as DATA read: read returns old byte, new byte stored, rxFull stays 1, no overrun.
- Errors (bits 3,4,5,7) sticky until clrErr; clrErr in same cycle as a new error: error wins.
- Baud: counter 0..max(BAUD,1)-1 runs while enable | txActive, else held at 0; baudTick when counter = max-1 (BAUD 0 or 1 → tick every cycle). BAUD write restarts counter at 0.
- irq = (txIrqEn & txEmpty & ~txActive) | (rxIrqEn & rxFull) | rxOverrun | parityErr | frameErr.

## Timing
- APB: one wait state. Access phase cycle N (pSelect&pEnable, pReady=0); cycle N+1 pReady=1, pRData valid, write/pop side effects committed on that edge; pReady drops next cycle. Setup phase ignored.
- Write DATA → LOAD no earlier than 1 cycle after the committing edge; txLoad occurs the cycle after FSM leaves IDLE.
- rxValid → STATUS/irq update visible next cycle.
- Reset asserted mid-frame: everything returns to reset values immediately; in-flight bytes lost.

## Test plan
- Reset, read all four registers → DATA 0, STATUS 0x02, CTRL 0, BAUD 16; each read shows pReady exactly one cycle after access phase.
- CTRL=1, write DATA 0xA5 → one txLoad with txFrame = 11'b1_0_10100101_0 (parity 0); FSM waits for txBusy rise/fall, then IDLE, txEmpty=1.
- Write 5 bytes with enable=0 (TX_DEPTH 4) → txFull=1, txOverflow=1; set enable → exactly 4 frames sent, in order.
- rxValid with frame carrying 0x3C, good parity/stop, then second frame before read → DATA read returns 0x3C, rxOverrun=1; clrErr clears it.
- rxFrame with stop=0 and wrong parity → frameErr=1, parityErr=1, irq=1 with irq enables 0.
- BAUD=3, enable=1 → baudTick every 3rd cycle; BAUD=0 → every cycle; assert pReset mid-frame → all outputs at reset values same cycle.

Source files
------------

// File: rtl/usrt_link_ctrl.sv
// APB-slave controller for the USRT serializer/deserializer pair: register file,
// TX byte FIFO with framing FSM, RX frame checking, baud-rate tick and interrupt.
module usrt_link_ctrl #(
  parameter int         TX_DEPTH = 4,
  parameter logic [7:0] BAUD_DIV = 8'd16
) (
  input  logic        pClk,
  input  logic        pReset,
  input  logic        pSelect,
  input  logic        pEnable,
  input  logic        pWrite,
  input  logic [32:0] pAddress,
  input  logic [7:0]  pWData,
  output logic [7:0]  pRData,
  output logic        pReady,
  output logic [10:0] txFrame,
  output logic        txLoad,
  input  logic        txBusy,
  input  logic [10:0] rxFrame,
  input  logic        rxValid,
  output logic        baudTick,
  output logic        irq
);

  localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WBUSY = 2'd2;
  localparam logic [1:0] S_WDONE = 2'd3;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_BAUD   = 2'd3;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  function automatic logic [10:0] make_frame(input logic [7:0] d);
    return {1'b1, even_parity(d), d, 1'b0};
  endfunction

  logic [7:0]  r_rdata;
  logic        r_ready;
  logic        r_enable, r_txie, r_rxie;
  logic [7:0]  r_baud;
  logic [7:0]  r_rx_byte;
  logic        r_rx_full, r_overrun, r_par_err, r_frm_err, r_tx_ovf;
  logic [1:0]  r_state;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [7:0]  r_mem [TX_DEPTH];
  logic [10:0] r_tx_frame;
  logic        r_tx_load;
  logic [7:0]  r_baud_cnt;
  logic        r_tick;
  logic        r_irq;

  logic        w_access, w_wr, w_rd;
  logic [1:0]  w_addr;
  logic        w_wr_data, w_rd_data, w_wr_ctrl, w_wr_baud, w_clr;
  logic        w_full, w_empty, w_active, w_start, w_push, w_ovf_set;
  logic [1:0]  w_state_n;
  logic [CW-1:0] w_count_n;
  logic [7:0]  w_status, w_rd_val;
  logic        w_rx_full_n, w_ovr_set, w_frm_set, w_par_set;
  logic [7:0]  w_rx_byte_n;
  logic        w_ovr_n, w_par_n, w_frm_n, w_txovf_n;
  logic        w_en_n, w_txie_n, w_rxie_n, w_irq_n;
  logic [7:0]  w_baud_max;
  logic        w_run;
  logic        w_unused_addr;

  assign w_unused_addr = ^{pAddress[32:4], pAddress[1:0]};

  // A transfer commits only once: the cycle pReady is high is not a new access.
  assign w_access  = pSelect & pEnable & ~r_ready;
  assign w_wr      = w_access & pWrite;
  assign w_rd      = w_access & ~pWrite;
  assign w_addr    = pAddress[3:2];
  assign w_wr_data = w_wr & (w_addr == A_DATA);
  assign w_rd_data = w_rd & (w_addr == A_DATA);
  assign w_wr_ctrl = w_wr & (w_addr == A_CTRL);
  assign w_wr_baud = w_wr & (w_addr == A_BAUD);
  assign w_clr     = w_wr_ctrl & pWData[3];

  assign w_full    = (r_count == CW'(TX_DEPTH));
  assign w_empty   = (r_count == {CW{1'b0}});
  assign w_active  = (r_state != S_IDLE);
  assign w_start   = (r_state == S_IDLE) & r_enable & ~w_empty;
  assign w_push    = w_wr_data & (~w_full | w_start);
  assign w_ovf_set = w_wr_data & w_full & ~w_start;

  assign w_status = {r_tx_ovf, w_active, r_frm_err, r_par_err,
                     r_overrun, r_rx_full, w_empty, w_full};

  always_comb begin
    w_rd_val = 8'd0;
    case (w_addr)
      A_DATA:   w_rd_val = r_rx_byte;
      A_STATUS: w_rd_val = w_status;
      A_CTRL:   w_rd_val = {5'd0, r_rxie, r_txie, r_enable};
      A_BAUD:   w_rd_val = r_baud;
      default:  w_rd_val = 8'd0;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_n = S_LOAD;  else w_state_n = S_IDLE;
      S_LOAD:  w_state_n = S_WBUSY;
      S_WBUSY: if (txBusy)  w_state_n = S_WDONE; else w_state_n = S_WBUSY;
      S_WDONE: if (!txBusy) w_state_n = S_IDLE;  else w_state_n = S_WDONE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_n = r_count;
    case ({w_push, w_start})
      2'b10:   w_count_n = r_count + CW'(1);
      2'b01:   w_count_n = r_count - CW'(1);
      default: w_count_n = r_count;
    endcase
  end

  // A DATA read in the same cycle as rxValid frees the buffer for the new byte.
  always_comb begin
    w_rx_full_n = r_rx_full;
    w_rx_byte_n = r_rx_byte;
    w_ovr_set   = 1'b0;
    if (rxValid) begin
      if (r_rx_full && !w_rd_data) begin
        w_ovr_set = 1'b1;
      end else begin
        w_rx_byte_n = rxFrame[8:1];
        w_rx_full_n = 1'b1;
      end
    end else if (w_rd_data) begin
      w_rx_full_n = 1'b0;
    end else begin
      w_rx_full_n = r_rx_full;
    end
  end

  assign w_frm_set = rxValid & (rxFrame[0] | ~rxFrame[10]);
  assign w_par_set = rxValid & (rxFrame[9] != even_parity(rxFrame[8:1]));

  assign w_ovr_n   = (r_overrun & ~w_clr) | w_ovr_set;
  assign w_par_n   = (r_par_err & ~w_clr) | w_par_set;
  assign w_frm_n   = (r_frm_err & ~w_clr) | w_frm_set;
  assign w_txovf_n = (r_tx_ovf  & ~w_clr) | w_ovf_set;

  assign w_en_n   = w_wr_ctrl ? pWData[0] : r_enable;
  assign w_txie_n = w_wr_ctrl ? pWData[1] : r_txie;
  assign w_rxie_n = w_wr_ctrl ? pWData[2] : r_rxie;

  assign w_irq_n = (w_txie_n & (w_count_n == {CW{1'b0}}) & (w_state_n == S_IDLE))
                 | (w_rxie_n & w_rx_full_n) | w_ovr_n | w_par_n | w_frm_n;

  assign w_baud_max = (r_baud < 8'd2) ? 8'd1 : r_baud;
  assign w_run      = r_enable | w_active;

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      r_ready <= 1'b0;
      r_rdata <= 8'd0;
    end else begin
      r_ready <= w_access;
      r_rdata <= w_rd ? w_rd_val : 8'd0;
    end
  end

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      r_enable  <= 1'b0;
      r_txie    <= 1'b0;
      r_rxie    <= 1'b0;
      r_baud    <= BAUD_DIV;
      r_rx_byte <= 8'd0;
      r_rx_full <= 1'b0;
      r_overrun <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_tx_ovf  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_enable  <= w_en_n;
      r_txie    <= w_txie_n;
      r_rxie    <= w_rxie_n;
      r_baud    <= w_wr_baud ? pWData : r_baud;
      r_rx_byte <= w_rx_byte_n;
      r_rx_full <= w_rx_full_n;
      r_overrun <= w_ovr_n;
      r_par_err <= w_par_n;
      r_frm_err <= w_frm_n;
      r_tx_ovf  <= w_txovf_n;
      r_irq     <= w_irq_n;
    end
  end

  always_ff @(posedge pClk) begin
    if (w_push) begin
      r_mem[r_wptr] <= pWData;
    end
  end

  // The head byte is popped and framed on the edge the FSM leaves IDLE.
  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      r_state    <= S_IDLE;
      r_count    <= {CW{1'b0}};
      r_wptr     <= {AW{1'b0}};
      r_rptr     <= {AW{1'b0}};
      r_tx_frame <= 11'h7FF;
      r_tx_load  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_count    <= w_count_n;
      r_wptr     <= w_push  ? r_wptr + AW'(1) : r_wptr;
      r_rptr     <= w_start ? r_rptr + AW'(1) : r_rptr;
      r_tx_frame <= w_start ? make_frame(r_mem[r_rptr]) : r_tx_frame;
      r_tx_load  <= w_start;
    end
  end

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      r_baud_cnt <= 8'd0;
      r_tick     <= 1'b0;
    end else if (w_wr_baud || !w_run) begin
      r_baud_cnt <= 8'd0;
      r_tick     <= 1'b0;
    end else begin
      r_tick     <= (r_baud_cnt == w_baud_max - 8'd1);
      r_baud_cnt <= (r_baud_cnt == w_baud_max - 8'd1) ? 8'd0 : r_baud_cnt + 8'd1;
    end
  end

  assign pRData   = r_rdata;
  assign pReady   = r_ready;
  assign txFrame  = r_tx_frame;
  assign txLoad   = r_tx_load;
  assign baudTick = r_tick;
  assign irq      = r_irq;

endmodule

// File: tb/tb_usrt_link_ctrl.sv
// Self-checking bench for usrt_link_ctrl: table-driven APB/RX vectors plus
// hand-written TX, overflow, baud and reset-mid-frame sequences.
module tb_usrt_link_ctrl;

  logic        pClk = 1'b0;
  logic        pReset;
  logic        pSelect, pEnable, pWrite;
  logic [32:0] pAddress;
  logic [7:0]  pWData;
  logic [7:0]  pRData;
  logic        pReady;
  logic [10:0] txFrame;
  logic        txLoad;
  logic        txBusy;
  logic [10:0] rxFrame;
  logic        rxValid;
  logic        baudTick;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pClk = ~pClk;

  usrt_link_ctrl #(.TX_DEPTH(4), .BAUD_DIV(8'd16)) dut (
    .pClk(pClk), .pReset(pReset), .pSelect(pSelect), .pEnable(pEnable),
    .pWrite(pWrite), .pAddress(pAddress), .pWData(pWData), .pRData(pRData),
    .pReady(pReady), .txFrame(txFrame), .txLoad(txLoad), .txBusy(txBusy),
    .rxFrame(rxFrame), .rxValid(rxValid), .baudTick(baudTick), .irq(irq)
  );

  // Serializer-side capture of every issued frame.
  logic [10:0] txq [$];
  logic        prev_load = 1'b0;
  int          dbl_load  = 0;
  always @(negedge pClk) begin
    if (pReset) begin
      prev_load <= 1'b0;
    end else begin
      if (txLoad) txq.push_back(txFrame);
      if (txLoad && prev_load) dbl_load <= dbl_load + 1;
      prev_load <= txLoad;
    end
  end

  typedef struct {
    int         kind;     // 0 APB write, 1 APB read+compare, 2 RX frame
    logic [1:0] addr;
    logic [10:0] data;
    logic [7:0] exp;
    bit         chk_irq;
    bit         exp_irq;
  } vec_t;
  vec_t vecs [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 1) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic apb(input logic wr, input logic [1:0] a, input logic [7:0] wd,
                     output logic [7:0] rd);
    int lat = 0;
    @(posedge pClk); #1;
    pSelect = 1'b1; pEnable = 1'b0; pWrite = wr; pWData = wd;
    pAddress = 33'h1_2345_6780 | {29'd0, a, 2'b11};
    @(posedge pClk); #1;
    pEnable = 1'b1;
    do begin
      @(posedge pClk); #1;
      lat++;
    end while (!pReady && lat < 4);
    chk("pready_latency", lat, 1);
    rd = pRData;
    pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    @(posedge pClk); #1;
    chk("pready_drop", {31'd0, pReady}, 0);
  endtask

  task automatic apb_wr(input logic [1:0] a, input logic [7:0] wd);
    logic [7:0] dummy;
    apb(1'b1, a, wd, dummy);
  endtask

  task automatic apb_rd_chk(input string nm, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] rd;
    apb(1'b0, a, 8'd0, rd);
    chk(nm, {24'd0, rd}, {24'd0, exp});
  endtask

  task automatic rx_frame(input logic [10:0] f);
    @(posedge pClk); #1;
    rxFrame = f; rxValid = 1'b1;
    @(posedge pClk); #1;
    rxValid = 1'b0;
  endtask

  task automatic wait_load();
    int k = 0;
    while (!txLoad && k < 30) begin
      @(posedge pClk); #1;
      k++;
    end
    chk("load_seen", {31'd0, txLoad}, 1);
  endtask

  task automatic serve_frame();
    wait_load();
    @(posedge pClk); #1;
    txBusy = 1'b1;
    repeat (3) @(posedge pClk);
    #1 txBusy = 1'b0;
  endtask

  task automatic count_ticks(input int cycles, output int n, output int bad_gap, input int gap);
    int last = -1;
    n = 0; bad_gap = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge pClk);
      if (baudTick) begin
        n++;
        if (last >= 0 && (c - last) != gap) bad_gap++;
        last = c;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_prdata"},   {24'd0, pRData}, 0);
    chk({tag, "_pready"},   {31'd0, pReady}, 0);
    chk({tag, "_txload"},   {31'd0, txLoad}, 0);
    chk({tag, "_baudtick"}, {31'd0, baudTick}, 0);
    chk({tag, "_irq"},      {31'd0, irq}, 0);
    chk({tag, "_txframe"},  {21'd0, txFrame}, 32'h7FF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int q0, n, gaps;
    vec_t v;

    pReset = 1'b1; pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    pAddress = 33'd0; pWData = 8'd0; txBusy = 1'b0; rxFrame = 11'h7FF; rxValid = 1'b0;

    // kind, addr, data, expected rdata, check irq, expected irq
    vecs.push_back('{1, 2'd0, 11'h000, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1, 2'd1, 11'h000, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{1, 2'd2, 11'h000, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1, 2'd3, 11'h000, 8'h10, 1'b0, 1'b0});
    vecs.push_back('{2, 2'd0, 11'h478, 8'h00, 1'b1, 1'b0});   // 0x3C good
    vecs.push_back('{1, 2'd1, 11'h000, 8'h06, 1'b0, 1'b0});
    vecs.push_back('{2, 2'd0, 11'h4AA, 8'h00, 1'b1, 1'b1});   // 0x55 -> overrun
    vecs.push_back('{1, 2'd1, 11'h000, 8'h0E, 1'b0, 1'b0});
    vecs.push_back('{1, 2'd0, 11'h000, 8'h3C, 1'b1, 1'b1});
    vecs.push_back('{1, 2'd1, 11'h000, 8'h0A, 1'b0, 1'b0});
    vecs.push_back('{0, 2'd2, 11'h008, 8'h00, 1'b1, 1'b0});   // clrErr
    vecs.push_back('{1, 2'd1, 11'h000, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{1, 2'd2, 11'h000, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{2, 2'd0, 11'h002, 8'h00, 1'b1, 1'b1});   // stop=0, bad parity
    vecs.push_back('{1, 2'd1, 11'h000, 8'h36, 1'b0, 1'b0});
    vecs.push_back('{1, 2'd0, 11'h000, 8'h01, 1'b1, 1'b1});
    vecs.push_back('{0, 2'd2, 11'h008, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{1, 2'd1, 11'h000, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{0, 2'd2, 11'h004, 8'h00, 1'b1, 1'b0});   // rxIrqEn
    vecs.push_back('{2, 2'd0, 11'h478, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{1, 2'd0, 11'h000, 8'h3C, 1'b1, 1'b0});
    vecs.push_back('{0, 2'd2, 11'h002, 8'h00, 1'b1, 1'b1});   // txIrqEn, idle+empty
    vecs.push_back('{0, 2'd2, 11'h000, 8'h00, 1'b1, 1'b0});

    repeat (3) @(negedge pClk);
    chk_reset_outputs("reset");
    @(posedge pClk); #1 pReset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      case (v.kind)
        0: apb_wr(v.addr, v.data[7:0]);
        1: begin
          apb(1'b0, v.addr, 8'd0, rd);
          chk($sformatf("vec%0d_rdata", i), {24'd0, rd}, {24'd0, v.exp});
        end
        default: rx_frame(v.data);
      endcase
      if (v.chk_irq) chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, v.exp_irq});
    end

    // Single byte: one load, frame 1_0_10100101_0, txActive until serializer done.
    q0 = txq.size();
    apb_wr(2'd2, 8'h01);
    apb_wr(2'd0, 8'hA5);
    repeat (8) @(negedge pClk);
    chk("a5_load_count", txq.size() - q0, 1);
    if (txq.size() > q0) begin
      chk("a5_frame", {21'd0, txq[q0]}, {21'd0, 11'b1_0_10100101_0});
    end
    apb_rd_chk("a5_status_active", 2'd1, 8'h42);
    @(posedge pClk); #1 txBusy = 1'b1;
    repeat (4) @(posedge pClk);
    #1 txBusy = 1'b0;
    repeat (3) @(posedge pClk);
    apb_rd_chk("a5_status_done", 2'd1, 8'h02);
    chk("a5_single_pulse", dbl_load, 0);

    // Five pushes into a 4-deep FIFO while disabled, then drain in order.
    apb_wr(2'd2, 8'h00);
    for (int i = 1; i <= 5; i++) apb_wr(2'd0, 8'(i * 8'h11));
    apb_rd_chk("ovf_status", 2'd1, 8'h81);
    q0 = txq.size();
    apb_wr(2'd2, 8'h01);
    for (int i = 0; i < 4; i++) serve_frame();
    repeat (12) @(posedge pClk);
    chk("ovf_frame_count", txq.size() - q0, 4);
    for (int i = 0; i < 4; i++) begin
      if (txq.size() > q0 + i)
        chk($sformatf("ovf_frame%0d", i), {21'd0, txq[q0+i]}, {21'd0, exp_frame(8'((i + 1) * 8'h11))});
    end
    apb_rd_chk("ovf_status_drained", 2'd1, 8'h82);
    apb_wr(2'd2, 8'h09);
    apb_rd_chk("ovf_status_cleared", 2'd1, 8'h02);

    // Baud tick spacing.
    apb_wr(2'd3, 8'd3);
    repeat (4) @(negedge pClk);
    count_ticks(30, n, gaps, 3);
    chk("baud3_count", n, 10);
    chk("baud3_gaps", gaps, 0);
    apb_wr(2'd3, 8'd0);
    repeat (2) @(negedge pClk);
    count_ticks(10, n, gaps, 1);
    chk("baud0_count", n, 10);
    apb_wr(2'd2, 8'h00);
    repeat (3) @(negedge pClk);
    count_ticks(20, n, gaps, 1);
    chk("baud_idle_count", n, 0);

    // Reset in the middle of a frame.
    apb_wr(2'd2, 8'h01);
    apb_wr(2'd0, 8'h77);
    wait_load();
    chk("pre_reset_tick", {31'd0, baudTick}, 1);
    chk("pre_reset_frame", {21'd0, txFrame}, {21'd0, exp_frame(8'h77)});
    pReset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    repeat (2) @(posedge pClk);
    #1 pReset = 1'b0;
    apb_rd_chk("post_reset_status", 2'd1, 8'h02);
    apb_rd_chk("post_reset_ctrl", 2'd2, 8'h00);
    apb_rd_chk("post_reset_baud", 2'd3, 8'h10);
    chk("post_reset_txframe", {21'd0, txFrame}, 32'h7FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
